layer4_fc_rx: RTL and testbench

Receiving end of the layer-3 output stream and the fully connected layer 4 of the LeNet datapath. Consumes the serial stream of 120 signed 16-bit activations and their indices, one word per enabled cycle. Drives the layer-4 weight ROM address, accumulates 84 dot products in parallel, then scales, saturates and presents them as one wide vector with a one-cycle `save` strobe, the same way layer 3 hands its result to its buffer.

---
 rtl/layer4_fc_rx_pkg.sv | 33 +++
 rtl/layer4_fc_rx_if.sv | 26 ++
 rtl/layer4_fc_rx_mac_lane.sv | 48 ++++
 rtl/layer4_fc_rx.sv | 155 +++++++++++++++
 tb/tb_layer4_fc_rx.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/layer4_fc_rx_pkg.sv
// Shared constants, FSM state encoding and saturation helper for the layer-4
// fully connected receiver.
package layer4_fc_rx_pkg;

   localparam int N_IN  = 120;
   localparam int N_OUT = 84;
   localparam int DW    = 16;
   localparam int FRAC  = 8;
   localparam int ACC_W = 40;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE  = 3'd0;
   localparam state_t S_ACC   = 3'd1;
   localparam state_t S_DRAIN = 3'd2;
   localparam state_t S_OUT   = 3'd3;
   localparam state_t S_DONE  = 3'd4;

   localparam logic signed [ACC_W-1:0] SAT_MAX = 40'sd32767;
   localparam logic signed [ACC_W-1:0] SAT_MIN = -40'sd32768;

   // Clamp a shifted accumulator into the signed Q7.8 output range.
   function automatic logic signed [DW-1:0] saturate(input logic signed [ACC_W-1:0] v);
      if (v > SAT_MAX) begin
         saturate = SAT_MAX[DW-1:0];
      end else if (v < SAT_MIN) begin
         saturate = SAT_MIN[DW-1:0];
      end else begin
         saturate = v[DW-1:0];
      end
   endfunction

endpackage

// File: rtl/layer4_fc_rx_if.sv
// Activation stream, weight ROM and result bus of the layer-4 receiver.
// The slave modport is the receiver side; master is the upstream/ROM side.
interface layer4_fc_rx_if;
   import layer4_fc_rx_pkg::*;

   logic signed [DW-1:0]    din;
   logic                    din_en;
   logic [7:0]              din_addr;
   logic [7:0]              weight_addr;
   logic [N_OUT*DW-1:0]     weight_in;
   logic [N_OUT*DW-1:0]     dout;
   logic                    save;
   logic                    fc_finish;
   logic                    seq_err;

   modport master (
      output din, din_en, din_addr, weight_in,
      input  weight_addr, dout, save, fc_finish, seq_err
   );

   modport slave (
      input  din, din_en, din_addr, weight_in,
      output weight_addr, dout, save, fc_finish, seq_err
   );

endinterface

// File: rtl/layer4_fc_rx_mac_lane.sv
// fc_mac_lane: one neuron's multiply-accumulate, Q7.8 rescale and saturation.
// Build option LAYER4_RELU_EN clamps negative saturated results to zero.
module fc_mac_lane
   import layer4_fc_rx_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clr,
   input  logic                    en,
   input  logic signed [DW-1:0]    a,
   input  logic signed [DW-1:0]    w,
   output logic signed [ACC_W-1:0] acc,
   output logic signed [DW-1:0]    sat
);

   logic signed [2*DW-1:0]  w_prod;
   logic signed [ACC_W-1:0] w_prod_ext;
   logic signed [ACC_W-1:0] w_shift;
   logic signed [ACC_W-1:0] r_acc;

   assign w_prod     = a * w;
   assign w_prod_ext = {{(ACC_W-2*DW){w_prod[2*DW-1]}}, w_prod};

   // Clear wins over accumulate so a new vector starts from exactly zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_acc <= '0;
      end else if (clr) begin
         r_acc <= '0;
      end else if (en) begin
         r_acc <= r_acc + w_prod_ext;
      end
   end

   assign acc     = r_acc;
   assign w_shift = r_acc >>> FRAC;

   always_comb begin
      sat = saturate(w_shift);
`ifdef LAYER4_RELU_EN
      if (sat[DW-1]) begin
         sat = '0;
      end
`else
`endif
   end

endmodule

// File: rtl/layer4_fc_rx.sv
// Layer-4 fully connected receiver: sequences the layer-3 stream, drives the
// weight ROM and presents N_OUT saturated dot products with a one-cycle save.
module layer4_fc_rx
   import layer4_fc_rx_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   layer4_fc_rx_if.slave  bus
);

   state_t                  r_state;
   logic                    r_drain_cnt;
   logic [7:0]              r_exp_idx;
   logic [7:0]              r_weight_addr;
   logic                    r_s1_en;
   logic                    r_s2_en;
   logic signed [DW-1:0]    r_s1_din;
   logic signed [DW-1:0]    r_s2_din;
   logic [N_OUT*DW-1:0]     r_dout;
   logic                    r_save;
   logic                    r_fc_finish;
   logic                    r_seq_err;

   logic                    w_accept;
   logic                    w_start;
   logic                    w_err;
   logic                    w_last;
   logic [N_OUT*DW-1:0]     w_sat;
   logic signed [ACC_W-1:0] w_acc_unused [N_OUT];

   // A wrong index in ACC aborts the vector; only a fresh index 0 restarts it.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path infers a latch.
      w_accept = 1'b0;
      w_start  = 1'b0;
      w_err    = 1'b0;
      if (bus.din_en) begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (bus.din_addr == 8'd0) begin
                  w_accept = 1'b1;
                  w_start  = 1'b1;
               end else begin
                  w_err = 1'b1;
               end
            end
            S_ACC: begin
               if (bus.din_addr == r_exp_idx) begin
                  w_accept = 1'b1;
               end else begin
                  w_err = 1'b1;
               end
            end
            default: w_err = 1'b1;
         endcase
      end
   end

   assign w_last = w_accept && (bus.din_addr == 8'(N_IN-1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= S_IDLE;
         r_drain_cnt   <= 1'b0;
         r_exp_idx     <= '0;
         r_weight_addr <= '0;
         r_dout        <= '0;
         r_save        <= 1'b0;
         r_fc_finish   <= 1'b0;
         r_seq_err     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments, so every register samples pre-edge values.
         r_save <= 1'b0;
         if (bus.din_en) begin
            r_weight_addr <= bus.din_addr;
         end
         if (w_err) begin
            r_seq_err <= 1'b1;
         end
         if (w_start) begin
            r_fc_finish <= 1'b0;
         end
         case (r_state)
            S_IDLE, S_DONE: begin
               if (w_start) begin
                  r_state   <= S_ACC;
                  r_exp_idx <= 8'd1;
               end
            end
            S_ACC: begin
               if (w_err) begin
                  r_state <= S_IDLE;
               end else if (w_accept) begin
                  r_exp_idx <= r_exp_idx + 8'd1;
                  if (w_last) begin
                     r_state     <= S_DRAIN;
                     r_drain_cnt <= 1'b0;
                  end
               end
            end
            S_DRAIN: begin
               if (r_drain_cnt) begin
                  r_state <= S_OUT;
               end else begin
                  r_drain_cnt <= 1'b1;
               end
            end
            S_OUT: begin
               r_dout      <= w_sat;
               r_save      <= 1'b1;
               r_fc_finish <= 1'b1;
               r_state     <= S_DONE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Two stages line the activation up with the registered ROM row.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_s1_en  <= 1'b0;
         r_s1_din <= '0;
         r_s2_en  <= 1'b0;
         r_s2_din <= '0;
      end else begin
         r_s1_en <= w_accept;
         if (w_accept) begin
            r_s1_din <= bus.din;
         end
         r_s2_en  <= r_s1_en;
         r_s2_din <= r_s1_din;
      end
   end

   for (genvar k = 0; k < N_OUT; k++) begin : g_lane
      fc_mac_lane u_lane (
         .clk   (clk),
         .reset (reset),
         .clr   (w_start),
         .en    (r_s2_en),
         .a     (r_s2_din),
         .w     (bus.weight_in[k*DW +: DW]),
         .acc   (w_acc_unused[k]),
         .sat   (w_sat[k*DW +: DW])
      );
   end

   assign bus.weight_addr = r_weight_addr;
   assign bus.dout        = r_dout;
   assign bus.save        = r_save;
   assign bus.fc_finish   = r_fc_finish;
   assign bus.seq_err     = r_seq_err;

endmodule

// File: tb/tb_layer4_fc_rx.sv
// Directed bench for layer4_fc_rx with a 1-cycle registered weight ROM model.
// Expectations follow the LAYER4_RELU_EN build option when it is defined.
module tb_layer4_fc_rx;
   import layer4_fc_rx_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b0;

   layer4_fc_rx_if bus ();

   layer4_fc_rx dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

`ifdef LAYER4_RELU_EN
   localparam bit RELU = 1'b1;
`else
   localparam bit RELU = 1'b0;
`endif

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int save_cnt = 0;
   int save_cyc = 0;

   int                 w_mode = 0;
   logic signed [15:0] w_const = 16'sh0100;
   logic signed [15:0] din_vec [N_IN];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.save === 1'b1) begin
         save_cnt <= save_cnt + 1;
         save_cyc <= cyc;
      end
   end

   // Weight table: 0 = constant, 1 = impulse row 0 ramp, 2 = address/lane pattern.
   function automatic logic signed [15:0] rom_w(input int a, input int k);
      case (w_mode)
         0:       return w_const;
         1:       return (a == 0) ? 16'((k - 42) * 256) : 16'sh0300;
         default: return 16'((((a * 13 + k * 29) % 256) - 128) * 2);
      endcase
   endfunction

   function automatic logic [N_OUT*DW-1:0] rom_row(input logic [7:0] a);
      logic [N_OUT*DW-1:0] row;
      for (int k = 0; k < N_OUT; k++) row[k*DW +: DW] = rom_w(int'(a), k);
      return row;
   endfunction

   always @(posedge clk) bus.weight_in <= rom_row(bus.weight_addr);

   function automatic int relu_f(input int v);
      return (RELU && v < 0) ? 0 : v;
   endfunction

   function automatic int model_lane(input int k);
      longint s = 0;
      for (int i = 0; i < N_IN; i++) s += longint'(din_vec[i]) * longint'(rom_w(i, k));
      s = s >>> 8;
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      return relu_f(int'(s));
   endfunction

   function automatic int lane(input int k);
      return int'($signed(bus.dout[k*DW +: DW]));
   endfunction

   task automatic fill(input logic signed [15:0] v);
      for (int i = 0; i < N_IN; i++) din_vec[i] = v;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic stream(input int from, input int gap, output int first);
      first = cyc;
      for (int i = from; i < N_IN; i++) begin
         bus.din_en   = 1'b1;
         bus.din_addr = 8'(i);
         bus.din      = din_vec[i];
         @(posedge clk); #1;
         if (i < N_IN - 1) begin
            repeat (gap) begin
               bus.din_en = 1'b0;
               @(posedge clk); #1;
            end
         end
      end
      bus.din_en = 1'b0;
   endtask

   task automatic wait_save(input int start_cnt, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk); #1;
         if (save_cnt != start_cnt) ok = 1'b1;
      end
   endtask

   task automatic test_reset;
      bus.din_en = 1'b0; bus.din = '0; bus.din_addr = '0;
      reset = 1'b0;
      idle(2);
      n_assert++; if (bus.dout !== '0) begin n_fail++; $display("FAIL reset_dout: lane0 got %0d required 0", lane(0)); end
      n_assert++; if (bus.save !== 1'b0) begin n_fail++; $display("FAIL reset_save: got %b required 0", bus.save); end
      n_assert++; if (bus.fc_finish !== 1'b0) begin n_fail++; $display("FAIL reset_fc_finish: got %b required 0", bus.fc_finish); end
      n_assert++; if (bus.seq_err !== 1'b0) begin n_fail++; $display("FAIL reset_seq_err: got %b required 0", bus.seq_err); end
      n_assert++; if (bus.weight_addr !== 8'd0) begin n_fail++; $display("FAIL reset_weight_addr: got %0d required 0", bus.weight_addr); end
      reset = 1'b1;
      idle(2);
   endtask

   task automatic test_unity;
      int f, s0; bit ok;
      w_mode = 0; w_const = 16'sh0100; fill(16'sh0100);
      s0 = save_cnt;
      stream(0, 0, f);
      wait_save(s0, 400, ok);
      n_assert++; if (!ok) begin n_fail++; $display("FAIL unity_save_timeout: got none required one save"); end
      n_assert++; if (save_cyc - f !== 123) begin n_fail++; $display("FAIL unity_latency: got %0d required 123", save_cyc - f); end
      n_assert++; if (bus.fc_finish !== 1'b1) begin n_fail++; $display("FAIL unity_fc_finish: got %b required 1", bus.fc_finish); end
      for (int k = 0; k < N_OUT; k++) begin
         n_assert++; if (lane(k) !== 30720) begin n_fail++; $display("FAIL unity_lane%0d: got %0d required 30720", k, lane(k)); end
      end
      @(negedge clk); #1;
      n_assert++; if (bus.save !== 1'b0) begin n_fail++; $display("FAIL unity_save_width: got %b required 0", bus.save); end
      n_assert++; if (save_cnt !== s0 + 1) begin n_fail++; $display("FAIL unity_save_count: got %0d required %0d", save_cnt, s0 + 1); end
      @(posedge clk); #1;
   endtask

   task automatic test_saturate;
      int f, s0; bit ok;
      w_mode = 0; w_const = 16'sh0100; fill(16'sh0200);
      s0 = save_cnt;
      stream(0, 0, f);
      wait_save(s0, 400, ok);
      n_assert++; if (!ok) begin n_fail++; $display("FAIL sat_pos_timeout: got none required one save"); end
      for (int k = 0; k < N_OUT; k++) begin
         n_assert++; if (lane(k) !== 32767) begin n_fail++; $display("FAIL sat_pos_lane%0d: got %0d required 32767", k, lane(k)); end
      end
      @(posedge clk); #1;
      w_const = 16'shFF00;
      s0 = save_cnt;
      stream(0, 0, f);
      wait_save(s0, 400, ok);
      n_assert++; if (!ok) begin n_fail++; $display("FAIL sat_neg_timeout: got none required one save"); end
      for (int k = 0; k < N_OUT; k++) begin
         n_assert++; if (lane(k) !== relu_f(-32768)) begin n_fail++; $display("FAIL sat_neg_lane%0d: got %0d required %0d", k, lane(k), relu_f(-32768)); end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_impulse(input int gap);
      int f, s0; bit ok;
      w_mode = 1; fill(16'sh0000); din_vec[0] = 16'sh0100;
      s0 = save_cnt;
      stream(0, gap, f);
      wait_save(s0, 800, ok);
      n_assert++; if (!ok) begin n_fail++; $display("FAIL impulse_gap%0d_timeout: got none required one save", gap); end
      n_assert++; if (save_cyc - f !== 123 + gap * (N_IN - 1)) begin
         n_fail++; $display("FAIL impulse_gap%0d_latency: got %0d required %0d", gap, save_cyc - f, 123 + gap * (N_IN - 1));
      end
      for (int k = 0; k < N_OUT; k++) begin
         n_assert++; if (lane(k) !== relu_f((k - 42) * 256)) begin
            n_fail++; $display("FAIL impulse_gap%0d_lane%0d: got %0d required %0d", gap, k, lane(k), relu_f((k - 42) * 256));
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_model;
      int f, s0; bit ok;
      w_mode = 2;
      for (int i = 0; i < N_IN; i++) din_vec[i] = 16'((((i * 37) % 200) - 100) * 4);
      s0 = save_cnt;
      stream(0, 0, f);
      wait_save(s0, 400, ok);
      n_assert++; if (!ok) begin n_fail++; $display("FAIL model_timeout: got none required one save"); end
      for (int k = 0; k < N_OUT; k++) begin
         n_assert++; if (lane(k) !== model_lane(k)) begin n_fail++; $display("FAIL model_lane%0d: got %0d required %0d", k, lane(k), model_lane(k)); end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back;
      int f1, f2, dummy, s0; bit ok;
      w_mode = 0; w_const = 16'sh0100; fill(16'sh0080);
      s0 = save_cnt;
      stream(0, 0, f1);
      fill(16'sh0040);
      idle(3);
      f2 = cyc;
      bus.din_en = 1'b1; bus.din_addr = 8'd0; bus.din = din_vec[0];
      @(negedge clk); #1;
      n_assert++; if (save_cnt !== s0 + 1) begin n_fail++; $display("FAIL b2b_first_save: got %0d saves required %0d", save_cnt, s0 + 1); end
      n_assert++; if (save_cyc - f1 !== 123) begin n_fail++; $display("FAIL b2b_first_latency: got %0d required 123", save_cyc - f1); end
      n_assert++; if (bus.fc_finish !== 1'b1) begin n_fail++; $display("FAIL b2b_finish_before: got %b required 1", bus.fc_finish); end
      for (int k = 0; k < N_OUT; k++) begin
         n_assert++; if (lane(k) !== 15360) begin n_fail++; $display("FAIL b2b_first_lane%0d: got %0d required 15360", k, lane(k)); end
      end
      @(posedge clk); #1;
      n_assert++; if (bus.fc_finish !== 1'b0) begin n_fail++; $display("FAIL b2b_finish_drop: got %b required 0", bus.fc_finish); end
      stream(1, 0, dummy);
      wait_save(s0 + 1, 400, ok);
      n_assert++; if (!ok) begin n_fail++; $display("FAIL b2b_second_timeout: got none required one save"); end
      n_assert++; if (save_cyc - f2 !== N_IN + 3) begin n_fail++; $display("FAIL b2b_second_latency: got %0d required %0d", save_cyc - f2, N_IN + 3); end
      for (int k = 0; k < N_OUT; k++) begin
         n_assert++; if (lane(k) !== 7680) begin n_fail++; $display("FAIL b2b_second_lane%0d: got %0d required 7680", k, lane(k)); end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_out_collision;
      int f, s0;
      w_mode = 1; fill(16'sh0000); din_vec[0] = 16'sh0100;
      s0 = save_cnt;
      stream(0, 0, f);
      idle(2);
      bus.din_en = 1'b1; bus.din_addr = 8'd0; bus.din = din_vec[0];
      @(posedge clk); #1;
      bus.din_en = 1'b0;
      @(negedge clk); #1;
      n_assert++; if (bus.seq_err !== 1'b1) begin n_fail++; $display("FAIL out_drop_seq_err: got %b required 1", bus.seq_err); end
      n_assert++; if (save_cnt !== s0 + 1) begin n_fail++; $display("FAIL out_drop_save: got %0d saves required %0d", save_cnt, s0 + 1); end
      for (int k = 0; k < N_OUT; k++) begin
         n_assert++; if (lane(k) !== relu_f((k - 42) * 256)) begin n_fail++; $display("FAIL out_drop_lane%0d: got %0d required %0d", k, lane(k), relu_f((k - 42) * 256)); end
      end
      @(posedge clk); #1;
      @(negedge clk); #1;
      n_assert++; if (bus.fc_finish !== 1'b1) begin n_fail++; $display("FAIL out_drop_finish: got %b required 1", bus.fc_finish); end
      n_assert++; if (save_cnt !== s0 + 1) begin n_fail++; $display("FAIL out_drop_no_restart: got %0d saves required %0d", save_cnt, s0 + 1); end
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      n_assert++; if (bus.seq_err !== 1'b0) begin n_fail++; $display("FAIL out_drop_reset_clear: got %b required 0", bus.seq_err); end
      idle(1);
      reset = 1'b1;
      idle(1);
   endtask

   task automatic test_seq_err;
      int f, s0; bit ok;
      int idx [3] = '{0, 1, 3};
      w_mode = 0; w_const = 16'sh0100; fill(16'sh0100);
      s0 = save_cnt;
      for (int j = 0; j < 3; j++) begin
         bus.din_en = 1'b1; bus.din_addr = 8'(idx[j]); bus.din = din_vec[idx[j]];
         @(posedge clk); #1;
      end
      bus.din_en = 1'b0;
      n_assert++; if (bus.seq_err !== 1'b1) begin n_fail++; $display("FAIL seq_err_set: got %b required 1", bus.seq_err); end
      stream(4, 0, f);
      idle(8);
      n_assert++; if (save_cnt !== s0) begin n_fail++; $display("FAIL seq_err_no_save: got %0d saves required %0d", save_cnt, s0); end
      stream(0, 0, f);
      wait_save(s0, 400, ok);
      n_assert++; if (!ok) begin n_fail++; $display("FAIL seq_err_restart_timeout: got none required one save"); end
      n_assert++; if (bus.seq_err !== 1'b1) begin n_fail++; $display("FAIL seq_err_sticky: got %b required 1", bus.seq_err); end
      for (int k = 0; k < N_OUT; k++) begin
         n_assert++; if (lane(k) !== 30720) begin n_fail++; $display("FAIL seq_err_restart_lane%0d: got %0d required 30720", k, lane(k)); end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_abort;
      int f, s0; bit ok;
      w_mode = 0; w_const = 16'sh0100; fill(16'sh0100);
      s0 = save_cnt;
      for (int i = 0; i < 60; i++) begin
         bus.din_en = 1'b1; bus.din_addr = 8'(i); bus.din = din_vec[i];
         @(posedge clk); #1;
      end
      bus.din_addr = 8'd60;
      #2;
      reset = 1'b0;
      #1;
      n_assert++; if (bus.dout !== '0) begin n_fail++; $display("FAIL abort_dout: lane0 got %0d required 0", lane(0)); end
      n_assert++; if (bus.fc_finish !== 1'b0) begin n_fail++; $display("FAIL abort_fc_finish: got %b required 0", bus.fc_finish); end
      n_assert++; if (bus.seq_err !== 1'b0) begin n_fail++; $display("FAIL abort_seq_err: got %b required 0", bus.seq_err); end
      n_assert++; if (bus.weight_addr !== 8'd0) begin n_fail++; $display("FAIL abort_weight_addr: got %0d required 0", bus.weight_addr); end
      bus.din_en = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      idle(6);
      n_assert++; if (save_cnt !== s0) begin n_fail++; $display("FAIL abort_no_save: got %0d saves required %0d", save_cnt, s0); end
      w_mode = 1; fill(16'sh0000); din_vec[0] = 16'sh0100;
      stream(0, 0, f);
      wait_save(s0, 400, ok);
      n_assert++; if (!ok) begin n_fail++; $display("FAIL abort_clean_timeout: got none required one save"); end
      n_assert++; if (save_cyc - f !== 123) begin n_fail++; $display("FAIL abort_clean_latency: got %0d required 123", save_cyc - f); end
      for (int k = 0; k < N_OUT; k++) begin
         n_assert++; if (lane(k) !== relu_f((k - 42) * 256)) begin n_fail++; $display("FAIL abort_clean_lane%0d: got %0d required %0d", k, lane(k), relu_f((k - 42) * 256)); end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_unity();
      test_saturate();
      test_impulse(0);
      test_impulse(1);
      test_model();
      test_back_to_back();
      test_out_collision();
      test_seq_err();
      test_reset_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
